// File: rtl/kernel_convolver.sv
// kernel_convolver: three-stage pipelined 3x3 convolver with valid/ready on
// both sides and full backpressure.
//
// Kernel is chosen per window by mode:
//   00 4-neighbour Laplacian, 01 weighted 8-neighbour Laplacian,
//   10 programmable signed coefficients, 11 centre pixel pass-through.
// S1 registers nine signed products. S2 registers three row sums. S3 (the
// output register) holds the shifted, saturated result.
//
// Optional build macro KERNEL_CONVOLVER_ABS_EN: a negative shifted sum is
// replaced by its magnitude, so only the high clamp can set sat_flag.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   window handshake (in_ready = pipeline advance)
//   window                nine pixels, pixel_k at [(k+1)*BPP-1 : k*BPP]
//   mode, out_shift       kernel select and arithmetic right shift, per window
//   coef_we/addr/data     programmable coefficient write port (addr 9..15 ignored)
//   out_valid / out_ready result handshake
//   conv_out, sat_flag    saturated result and clip indicator
module kernel_convolver #(
   parameter int BIT_PER_PIXEL = 8,
   parameter int COEF_WIDTH    = 5,
   parameter int ACC_WIDTH     = BIT_PER_PIXEL + COEF_WIDTH + 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [9*BIT_PER_PIXEL-1:0]    window,
   input  logic [1:0]                    mode,
   input  logic [3:0]                    out_shift,
   input  logic                          coef_we,
   input  logic [3:0]                    coef_addr,
   input  logic [COEF_WIDTH-1:0]         coef_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BIT_PER_PIXEL-1:0]      conv_out,
   output logic                          sat_flag
);

   localparam int PW = BIT_PER_PIXEL;
   localparam logic [1:0] MODE_LAP4 = 2'b00;
   localparam logic [1:0] MODE_LAP8 = 2'b01;
   localparam logic [1:0] MODE_PROG = 2'b10;
   localparam logic [1:0] MODE_PASS = 2'b11;
   localparam int LAP4 [9] = '{0, 1, 0, 1, -4, 1, 0, 1, 0};
   localparam int LAP8 [9] = '{1, 2, 1, 2, -12, 2, 1, 2, 1};
   localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << PW) - 1);

   logic signed [COEF_WIDTH-1:0] r_coef [9];

   logic                         r_s1_valid;
   logic [1:0]                   r_s1_mode;
   logic [3:0]                   r_s1_shift;
   logic signed [ACC_WIDTH-1:0]  r_s1_prod [9];

   logic                         r_s2_valid;
   logic [1:0]                   r_s2_mode;
   logic [3:0]                   r_s2_shift;
   logic signed [ACC_WIDTH-1:0]  r_s2_row [3];

   logic                         r_out_valid;
   logic [PW-1:0]                r_conv;
   logic                         r_sat;

   logic                         w_advance;
   logic signed [ACC_WIDTH-1:0]  w_kern [9];
   logic signed [ACC_WIDTH-1:0]  w_pix [9];
   logic signed [ACC_WIDTH-1:0]  w_prod [9];
   logic signed [ACC_WIDTH-1:0]  w_sum;
   logic signed [ACC_WIDTH-1:0]  w_shifted;
`ifdef KERNEL_CONVOLVER_ABS_EN
   logic signed [ACC_WIDTH-1:0]  w_mag;
`endif
   logic [PW-1:0]                w_res;
   logic                         w_sat;

   assign w_advance = ~r_out_valid | out_ready;
   assign in_ready  = w_advance;
   assign out_valid = r_out_valid;
   assign conv_out  = r_conv;
   assign sat_flag  = r_sat;

   // Pass-through is realised as an identity kernel so it shares the
   // datapath; S3 then bypasses shift and saturation for that mode.
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         w_pix[k]  = {{(ACC_WIDTH-PW){1'b0}}, window[k*PW +: PW]};
         w_kern[k] = '0;
         case (mode)
            MODE_LAP4: w_kern[k] = ACC_WIDTH'(LAP4[k]);
            MODE_LAP8: w_kern[k] = ACC_WIDTH'(LAP8[k]);
            MODE_PROG: w_kern[k] = {{(ACC_WIDTH-COEF_WIDTH){r_coef[k][COEF_WIDTH-1]}}, r_coef[k]};
            default:   w_kern[k] = (k == 4) ? ACC_WIDTH'(1) : '0;
         endcase
         w_prod[k] = w_pix[k] * w_kern[k];
      end
   end

   always_comb begin
      w_sum     = r_s2_row[0] + r_s2_row[1] + r_s2_row[2];
      w_shifted = w_sum >>> r_s2_shift;
      w_res     = '0;
      w_sat     = 1'b0;
`ifdef KERNEL_CONVOLVER_ABS_EN
      w_mag     = (w_shifted < 0) ? -w_shifted : w_shifted;
`endif
      if (r_s2_mode == MODE_PASS) begin
         w_res = w_sum[PW-1:0];
      end else begin
`ifdef KERNEL_CONVOLVER_ABS_EN
         if (w_mag > PIX_MAX) begin
            w_res = '1;
            w_sat = 1'b1;
         end else begin
            w_res = w_mag[PW-1:0];
         end
`else
         if (w_shifted < 0) begin
            w_res = '0;
            w_sat = 1'b1;
         end else if (w_shifted > PIX_MAX) begin
            w_res = '1;
            w_sat = 1'b1;
         end else begin
            w_res = w_shifted[PW-1:0];
         end
`endif
      end
   end

   // Pipeline: every stage moves together on advance, otherwise all hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_mode   <= '0;
         r_s1_shift  <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_mode   <= '0;
         r_s2_shift  <= '0;
         r_out_valid <= 1'b0;
         r_conv      <= '0;
         r_sat       <= 1'b0;
         for (int k = 0; k < 9; k++) r_s1_prod[k] <= '0;
         for (int r = 0; r < 3; r++) r_s2_row[r]  <= '0;
      end else if (w_advance) begin
         r_s1_valid <= in_valid;
         r_s1_mode  <= mode;
         r_s1_shift <= out_shift;
         for (int k = 0; k < 9; k++) r_s1_prod[k] <= w_prod[k];

         r_s2_valid <= r_s1_valid;
         r_s2_mode  <= r_s1_mode;
         r_s2_shift <= r_s1_shift;
         for (int r = 0; r < 3; r++)
            r_s2_row[r] <= r_s1_prod[3*r] + r_s1_prod[3*r+1] + r_s1_prod[3*r+2];

         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_conv <= w_res;
            r_sat  <= w_sat;
         end
      end
   end

   // Coefficients reset to the identity kernel. A window accepted on the
   // same edge as a write already sampled the old value through w_prod.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 9; k++)
            r_coef[k] <= (k == 4) ? COEF_WIDTH'(1) : '0;
      end else begin
         for (int k = 0; k < 9; k++)
            if (coef_we && (coef_addr == 4'(k))) r_coef[k] <= coef_data;
      end
   end

endmodule
